// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Framing constants, baud divisor helper and the transmitter FSM state type.
//   Both UART ends import this package so they agree on the frame format.
//
//   Contents:
//     DATA_BITS        payload bits per frame (LSB first)
//     STOP_BITS        stop bits per frame
//     baud_div()       clocks per bit, CLK_FREQ/BAUD_RATE, integer-truncated
//     uart_tx_state_t  transmitter FSM states
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;

   // Clocks per serial bit. The truncation is deliberate: both ends use the
   // same divisor, so they stay in step with each other.
   function automatic int baud_div(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

   // ST_PARITY is always part of the type so that the encoding does not change
   // between builds; it is only reachable when parity is compiled in.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   Synchronous show-ahead FIFO that buffers bytes for the UART transmitter.
//   The pointers carry one extra wrap bit, so a full FIFO and an empty FIFO can
//   be told apart without a separate occupancy counter.
//
//   Parameters:
//     DEPTH  number of entries; must be a power of two and at least 2
//     WIDTH  entry width in bits
//   Ports:
//     clk    rising-edge clock
//     rst    asynchronous active-high reset; empties the FIFO
//     push   write din; ignored while full
//     pop    discard the head entry; ignored while empty
//     din    write data
//     dout   head entry; valid while empty is low
//     full   no free entry
//     empty  no stored entry
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   // Pointers wrap modulo 2*DEPTH. Equal pointers mean empty; pointers that
   // differ only in the wrap bit mean full.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   // Show-ahead read: the head entry is always presented on dout.
   assign dout = mem[rd_ptr_q[AW-1:0]];

   always_comb begin
      do_push  = push & ~full;
      do_pop   = pop & ~empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: resetting the pointers discards its contents.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_q[AW-1:0]] <= din;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//   UART transmitter. Bytes arrive over a valid/ready handshake, queue in a
//   small FIFO and leave LSB-first on TxD as 8N1 frames. Consecutive frames
//   follow each other with no idle time beyond the stop bit.
//
//   Optional feature (compile-time macro UART_TX_PARITY_EN):
//     defined   -> an even parity bit follows the data bits (8E1 frames)
//     undefined -> no parity bit (8N1 frames, what the receiver expects)
//
//   Parameters:
//     CLK_FREQ    clock frequency in Hz
//     BAUD_RATE   line rate in bit/s
//     FIFO_DEPTH  input FIFO entries; power of two, at least 2
//   Ports:
//     clk_fpga    rising-edge clock
//     reset       asynchronous active-high reset; aborts any frame
//     data_in     byte to send, taken when data_valid && data_ready
//     data_valid  producer offers data_in
//     data_ready  FIFO has room
//     TxD         serial line, idle high, driven straight from a flop
//     busy        FIFO holds data or a frame is on the line
// -----------------------------------------------------------------------------
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD_RATE  = 9_600,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk_fpga,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       data_valid,
   output logic       data_ready,
   output logic       TxD,
   output logic       busy
);

   localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE);
   localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int IDX_W    = $clog2(DATA_BITS);

   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
   localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

   uart_tx_state_t       state_q, state_d;
   logic [CNT_W-1:0]     baud_cnt_q, baud_cnt_d;
   logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 txd_q, txd_d;
`ifdef UART_TX_PARITY_EN
   logic                 parity_q, parity_d;
`endif

   logic                 fifo_push;
   logic                 fifo_pop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [DATA_BITS-1:0] fifo_dout;
   logic                 baud_tick;

   // ---------------------------------------------------------------------------
   // Input buffer
   // ---------------------------------------------------------------------------
   assign data_ready = ~fifo_full;
   assign fifo_push  = data_valid & ~fifo_full;

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_BITS)
   ) u_fifo (
      .clk   (clk_fpga),
      .rst   (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (data_in),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // ---------------------------------------------------------------------------
   // Framing FSM
   // ---------------------------------------------------------------------------
   // baud_tick marks the last clock of the current bit period.
   assign baud_tick = (baud_cnt_q == BAUD_LAST);

   // txd_d is the line level for the state being entered, so TxD changes on
   // the same edge as the state and stays glitch-free.
   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_tick ? '0 : baud_cnt_q + CNT_W'(1);
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      txd_d      = txd_q;
      fifo_pop   = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d   = parity_q;
`endif

      case (state_q)
         ST_IDLE: begin
            baud_cnt_d = '0;
            bit_idx_d  = '0;
            txd_d      = 1'b1;
            fifo_pop   = ~fifo_empty;
         end

         ST_START: begin
            if (baud_tick) begin
               state_d = ST_DATA;
               txd_d   = shift_q[0];
            end
         end

         ST_DATA: begin
            if (baud_tick) begin
               shift_d = shift_q >> 1;
               if (bit_idx_q == DATA_LAST) begin
                  bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d   = ST_PARITY;
                  txd_d     = parity_q;
`else
                  state_d   = ST_STOP;
                  txd_d     = 1'b1;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + IDX_W'(1);
                  // Next bit is shift_q[1]: it becomes bit 0 after this shift.
                  txd_d     = shift_q[1];
               end
            end
         end

`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (baud_tick) begin
               state_d = ST_STOP;
               txd_d   = 1'b1;
            end
         end
`endif

         ST_STOP: begin
            if (baud_tick) begin
               if (bit_idx_q != STOP_LAST) begin
                  bit_idx_d = bit_idx_q + IDX_W'(1);
               end else if (!fifo_empty) begin
                  // Chain straight into the next start bit: no idle gap.
                  fifo_pop = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  txd_d   = 1'b1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            txd_d   = 1'b1;
         end
      endcase

      // Every pop starts a new frame, whether from IDLE or at the end of STOP.
      if (fifo_pop) begin
         shift_d    = fifo_dout;
         baud_cnt_d = '0;
         bit_idx_d  = '0;
         state_d    = ST_START;
         txd_d      = 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_d   = ^fifo_dout;
`endif
      end
   end

   always_ff @(posedge clk_fpga or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         baud_cnt_q <= '0;
         bit_idx_q  <= '0;
         txd_q      <= 1'b1;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_idx_q  <= bit_idx_d;
         txd_q      <= txd_d;
      end
   end

   // Shift register and parity are pure data: always reloaded before use.
   always_ff @(posedge clk_fpga) begin
      shift_q  <= shift_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
   end

   assign TxD  = txd_q;
   assign busy = (state_q != ST_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
//   Bench for uart_tx at CLK_FREQ=1 MHz, BAUD_RATE=100 kbit/s (10 clocks/bit).
//   A reference model tracks the byte queue and frame start times with plain
//   arithmetic and predicts TxD, busy and data_ready after every clock edge.
//   A table of bytes with hand-written line patterns is sampled mid-bit, and
//   hand-written sequences cover exact latency, back-to-back frames, a full
//   FIFO and reset in the middle of a frame. Honours UART_TX_PARITY_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx;

   localparam int CLK_FREQ = 1_000_000;
   localparam int BAUD     = 100_000;
   localparam int DEPTH    = 4;
   localparam int BD       = 10;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME    = 11;
`else
   localparam int FRAME    = 10;
`endif

   logic       clk        = 1'b0;
   logic       reset      = 1'b1;
   logic [7:0] data_in    = 8'h00;
   logic       data_valid = 1'b0;
   logic       data_ready;
   logic       TxD;
   logic       busy;

   uart_tx #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD_RATE  (BAUD),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk_fpga   (clk),
      .reset      (reset),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .TxD        (TxD),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // Reference model: queued bytes plus the byte on the line and its start edge.
   logic [7:0] m_fifo[$];
   bit         m_act = 1'b0;
   int         m_start = 0;
   logic [7:0] m_byte = 8'h00;
   bit         m_acc = 1'b0;

   typedef struct {
      logic [7:0] b;
      logic [9:0] pat;   // {stop, data[7:0], start} as seen on the line
      logic       par;
   } vec_t;
   vec_t tbl[7];

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      m_fifo.delete();
      m_act = 1'b0;
      m_acc = 1'b0;
   endtask

   // One clock edge of the model: frame end, pop, then push.
   task automatic model_step();
      bit take;
      m_acc = 1'b0;
      if (reset) begin
         model_reset();
         return;
      end
      take = data_valid && (m_fifo.size() < DEPTH);
      if (m_act && (cyc - m_start) >= FRAME * BD) m_act = 1'b0;
      if (!m_act && m_fifo.size() != 0) begin
         m_byte  = m_fifo.pop_front();
         m_start = cyc;
         m_act   = 1'b1;
      end
      if (take) begin
         m_fifo.push_back(data_in);
         m_acc = 1'b1;
      end
   endtask

   function automatic logic m_line();
      int j;
      if (!m_act) return 1'b1;
      j = (cyc - m_start) / BD;
      if (j == 0) return 1'b0;
      if (j <= 8) return m_byte[j-1];
      if (j < FRAME - 1) return ^m_byte;
      return 1'b1;
   endfunction

   function automatic logic m_busy();
      return m_act || (m_fifo.size() != 0);
   endfunction

   function automatic logic m_rdy();
      return m_fifo.size() < DEPTH;
   endfunction

   task automatic tick();
      @(posedge clk);
      cyc++;
      model_step();
      #2;
      check("line", {13'd0, TxD, busy, data_ready}, {13'd0, m_line(), m_busy(), m_rdy()});
   endtask

   task automatic wait_idle(input int max_cyc);
      int n = 0;
      while (m_busy() && n < max_cyc) begin
         tick();
         n++;
      end
      if (m_busy()) begin
         n_vec++;
         n_err++;
         $display("FAIL idle_timeout cyc=%0d got=busy want=idle", cyc);
      end
   endtask

   task automatic send_one(input logic [7:0] b);
      data_in    = b;
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
   endtask

   initial begin
      int e, d, acc, last;
      logic [10:0] got, expv;

      tbl[0] = '{8'h55, 10'h2AA, 1'b0};
      tbl[1] = '{8'h00, 10'h200, 1'b0};
      tbl[2] = '{8'hFF, 10'h3FE, 1'b0};
      tbl[3] = '{8'hA3, 10'h346, 1'b0};
      tbl[4] = '{8'h0F, 10'h21E, 1'b0};
      tbl[5] = '{8'h01, 10'h202, 1'b1};
      tbl[6] = '{8'h80, 10'h300, 1'b1};

      // Reset state (checked by tick against the idle model).
      repeat (3) tick();
      check("rst_txd", {15'd0, TxD}, 16'd1);
      check("rst_busy", {15'd0, busy}, 16'd0);
      check("rst_ready", {15'd0, data_ready}, 16'd1);
      reset = 1'b0;
      repeat (3) tick();

      // Single byte 0x55: exact latency of every bit boundary.
      send_one(8'h55);
      e = cyc;
      check("s55_busy_at_push", {15'd0, busy}, 16'd1);
      d = 0;
      while (d < 1 + FRAME * BD) begin
         tick();
         d = cyc - e;
         if (d == 1 || d == BD)                    check("s55_start", {15'd0, TxD}, 16'd0);
         if (d == 1 + BD)                          check("s55_bit0", {15'd0, TxD}, 16'd1);
         if (d == 2 * BD)                          check("s55_bit0_end", {15'd0, TxD}, 16'd1);
         if (d == 1 + 2 * BD)                      check("s55_bit1", {15'd0, TxD}, 16'd0);
         if (d == 1 + (FRAME - 1) * BD)            check("s55_stop_first", {14'd0, TxD, busy}, 16'd3);
         if (d == FRAME * BD)                      check("s55_stop_last", {14'd0, TxD, busy}, 16'd3);
         if (d == 1 + FRAME * BD)                  check("s55_busy_fall", {14'd0, TxD, busy}, 16'd2);
      end

      // Back-to-back 0xA3, 0x0F: second start bit right after first stop bit.
      repeat (5) tick();
      data_in = 8'hA3; data_valid = 1'b1;
      tick();
      e = cyc;
      data_in = 8'h0F;
      tick();
      data_valid = 1'b0;
      d = cyc - e;
      while (d < 1 + 2 * FRAME * BD) begin
         tick();
         d = cyc - e;
         if (d == 1 + BD)                 check("b2b_a3_bit0", {15'd0, TxD}, 16'd1);
         if (d == 1 + 3 * BD)             check("b2b_a3_bit2", {15'd0, TxD}, 16'd0);
         if (d == FRAME * BD)             check("b2b_stop1", {15'd0, TxD}, 16'd1);
         if (d == 1 + FRAME * BD)         check("b2b_start2", {14'd0, TxD, busy}, 16'd1);
         if (d == 1 + FRAME * BD + BD)    check("b2b_0f_bit0", {15'd0, TxD}, 16'd1);
         if (d == 1 + FRAME * BD + 5 * BD) check("b2b_0f_bit4", {15'd0, TxD}, 16'd0);
      end
      wait_idle(100);

      // Table: sample every bit in the middle of its period.
      for (int k = 0; k < 7; k++) begin
         wait_idle(2000);
         repeat (2) tick();
         send_one(tbl[k].b);
         e = cyc;
         got = '0;
         d = 0;
         while (d < FRAME * BD) begin
            tick();
            d = cyc - e;
            for (int j = 0; j < FRAME; j++) begin
               if (d == 1 + j * BD + BD / 2) got[j] = TxD;
            end
         end
         expv = (FRAME == 11) ? {1'b1, tbl[k].par, tbl[k].pat[8:0]} : {1'b0, tbl[k].pat};
         check($sformatf("tbl_%02h", tbl[k].b), {5'd0, got}, {5'd0, expv});
      end
      wait_idle(200);

      // FIFO full: five accepts, then the sixth waits for the first stop pop.
      data_in = 8'h01; data_valid = 1'b1;
      acc = 0; e = 0; last = 0;
      for (int n = 0; n < 3000 && acc < 6; n++) begin
         tick();
         if (m_acc) begin
            acc++;
            if (acc == 1) e = cyc;
            if (acc == 5) check("full_ready_low", {15'd0, data_ready}, 16'd0);
            if (acc == 6) last = cyc;
            data_in = 8'(acc + 1);
         end
      end
      data_valid = 1'b0;
      check("full_accepts", 16'(acc), 16'd6);
      check("full_6th_delay", 16'(last - e), 16'(2 + FRAME * BD));
      wait_idle(8 * FRAME * BD);

      // Reset during data bit 3 of 0xFF with two bytes queued behind it.
      repeat (3) tick();
      data_in = 8'hFF; data_valid = 1'b1;
      tick();
      e = cyc;
      data_in = 8'h11; tick();
      data_in = 8'h22; tick();
      data_valid = 1'b0;
      while (cyc - e < 1 + 4 * BD + 3) tick();
      reset = 1'b1;
      #1;
      check("midrst_line", {13'd0, TxD, busy, data_ready}, 16'd5);
      model_reset();
      repeat (3) tick();
      reset = 1'b0;
      repeat (3 * FRAME * BD) tick();
      check("midrst_quiet", {14'd0, TxD, busy}, 16'd2);

      // Random traffic against the model.
      for (int n = 0; n < 4000; n++) begin
         data_valid = ($urandom_range(0, 99) < 35);
         data_in    = 8'($urandom);
         tick();
      end
      data_valid = 1'b0;
      wait_idle((DEPTH + 2) * FRAME * BD);
      check("end_idle", {13'd0, TxD, busy, data_ready}, 16'd5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
